// File: rtl/byte_transmitter.sv
// Serializes a WIDTH-bit word LSB first: first bit appears on the start edge, done on the (WIDTH+1)-th enabled edge.
// enable low pauses the shift with no bit lost or repeated; DONE is sticky until reset.
module byte_transmitter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_q, out_d;
  logic             done_q, done_d;

  // shreg holds the bits not yet presented, so the next bit is always shreg[0]
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    out_d   = out_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        out_d  = 1'b0;
        done_d = 1'b0;
        if (enable) begin
          shreg_d = in >> 1;
          out_d   = in[0];
          count_d = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        done_d = 1'b0;
        if (enable) begin
          if (count_q < CW'(WIDTH)) begin
            out_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            count_d = count_q + CW'(1);
          end else begin
            out_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_byte_transmitter.sv
// Scoreboard bench for byte_transmitter: directed scenarios plus random words with random pauses and resets.
module tb_byte_transmitter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] din;
  logic         out;
  logic         done;

  always #5 clk = ~clk;

  byte_transmitter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (din),
    .out    (out),
    .done   (done)
  );

  typedef struct {
    logic  o;
    logic  d;
    string tag;
  } exp_t;

  exp_t  sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  string cur_tag  = "reset";

  // Reference: a transfer is a word plus how many of its bits have been shown.
  int           busy  = 0;
  int           fin   = 0;
  int           shown = 0;
  logic [W-1:0] word  = '0;

  task automatic predict(input logic r, input logic e, input logic [W-1:0] d);
    exp_t x;
    x.tag = cur_tag;
    x.o   = 1'b0;
    x.d   = 1'b0;
    if (r) begin
      busy = 0; fin = 0; shown = 0; word = '0;
    end else if (fin != 0) begin
      x.d = 1'b1;
    end else if (busy == 0) begin
      if (e) begin
        word  = d;
        shown = 1;
        busy  = 1;
        x.o   = d[0];
      end
    end else if (e) begin
      if (shown < W) begin
        x.o   = word[shown];
        shown = shown + 1;
      end else begin
        fin  = 1;
        busy = 0;
        x.d  = 1'b1;
      end
    end else begin
      x.o = word[shown-1];
    end
    sb_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
    @(negedge clk);
    reset  = r;
    enable = e;
    din    = d;
    predict(r, e, d);
  endtask

  task automatic run(input int n, input logic e, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) drive(1'b0, e, d);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (out !== x.o) begin
          failures++;
          $display("FAIL %s out cyc=%0d got=%b exp=%b", x.tag, cyc, out, x.o);
        end
        checks++;
        if (done !== x.d) begin
          failures++;
          $display("FAIL %s done cyc=%0d got=%b exp=%b", x.tag, cyc, done, x.d);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rw;
    reset  = 1'b1;
    enable = 1'b0;
    din    = '0;

    cur_tag = "reset";
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    run(4, 1'b0, '0);

    cur_tag = "full";
    run(40, 1'b1, 32'h000FAF01);
    drive(1'b1, 1'b0, '0);

    cur_tag = "pause";
    run(6, 1'b1, 32'hA5A5A5A5);
    run(3, 1'b0, 32'hA5A5A5A5);
    run(30, 1'b1, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, '0);

    // reset held with enable high: the new transfer starts on the release edge
    cur_tag = "midreset";
    run(11, 1'b1, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 32'h00000001);
    run(36, 1'b1, 32'h00000001);

    cur_tag = "sticky";
    for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    cur_tag = "stable";
    drive(1'b0, 1'b1, 32'h0000FFFF);
    run(35, 1'b1, 32'hFFFF0000);
    drive(1'b1, 1'b0, '0);

    cur_tag = "random";
    for (int t = 0; t < 6; t++) begin
      rw = $urandom;
      for (int c = 0; c < 60; c++)
        drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) != 0) ? rw : W'($urandom));
      drive(1'b1, 1'b0, '0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_transmitter.md
BYTE_TRANSMITTER -- requirements
Module: byte_transmitter

Interface
REQ-001 Parameter: WIDTH, default 32, number of bits serialized per transfer.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  start a transfer when idle; advance the shift when active; low pauses.
REQ-005 in  input  WIDTH  parallel word to serialize; sampled only at transfer start.
REQ-006 out  output  1  registered serial data, LSB first.
REQ-007 done  output  1  registered flag, high once all WIDTH bits have been presented.

Function
REQ-008 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-009 The block SHALL hold an internal WIDTH-bit shift register and a bit counter wide enough to hold WIDTH.
REQ-010 In IDLE with enable=1, a rising edge SHALL:
- capture in;
- drive out <= in[0];
- set count to 1;
- go to SHIFT.
REQ-011 In IDLE with enable=0, out SHALL be 0, done SHALL be 0, and the state SHALL hold.
REQ-012 In SHIFT with enable=1 and count<WIDTH, each edge SHALL drive out <= captured[count] and increment count.
- Result: out equals in[k] after the k-th edge counted from the start edge (k=0..WIDTH-1).
REQ-013 In SHIFT with enable=1 and count==WIDTH, the next edge SHALL drive out <= 0 and done <= 1, and go to DONE.
REQ-014 In SHIFT with enable=0, out, count and the captured word SHALL hold (pause, no bit lost or repeated).
REQ-015 In DONE, done SHALL stay 1 and out SHALL stay 0 regardless of enable or in; only reset leaves DONE.
REQ-016 A change on in after the start edge SHALL NOT affect the serialized data.
REQ-017 done SHALL be 0 in IDLE and SHIFT.
REQ-018 Timing: done rises exactly WIDTH+1 enabled edges after the start edge's predecessor, i.e. on the (WIDTH+1)-th enabled edge counting the start edge as 1.
REQ-019 out and done SHALL never be X after the first reset edge.

Reset
REQ-020 When reset=1 at a rising edge, the block SHALL set state=IDLE, out=0, done=0, count=0 and captured word=0.
REQ-021 Reset SHALL take priority over enable in every state, including mid-SHIFT and DONE; the transfer is abandoned with no residual output.
REQ-022 With enable=1 held through the reset release, a new transfer SHALL start on the first edge with reset=0.

Verification
REQ-023 Reset scenario:
- Stimulus: reset=1 for 2 edges, then reset=0, enable=0.
- Required: out=0 and done=0 on every cycle.
REQ-024 Full transfer:
- Stimulus: in=32'h000FAF01, enable=1 continuously.
- Required: out sequence 1,0,0,0,0,0,0,0,1,1,1,1,0,1,0,1,1,1,1,1, then 0 for bits 20..31.
- Then: done=1 and out=0 on edge 33, held thereafter.
REQ-025 Pause:
- Stimulus: in=32'hA5A5A5A5; drop enable for 3 cycles after bit 5.
- Required: out holds bit 5 during the pause; on resume the sequence continues from bit 6; done is delayed by exactly 3 cycles.
REQ-026 Reset mid-transfer:
- Stimulus: assert reset after bit 10 of 32'hFFFFFFFF.
- Required: out=0 and done=0 next edge; a new transfer of 32'h00000001 then yields out=1, then 31 zeros, then done=1.
REQ-027 Input stability:
- Stimulus: start with in=32'h0000FFFF; change in to 32'hFFFF0000 on the edge after start.
- Required: serialized stream still equals 32'h0000FFFF, LSB first.
REQ-028 DONE stickiness:
- Stimulus: after done=1, toggle enable and in for 10 cycles.
- Required: done=1 and out=0 throughout; reset=1 returns done=0.
